// File: rtl/rega_pkg.sv
// Shared types and defaults for the irrigation countdown timer.
// Table entries are {DM,UM,DS,US} in BCD, entry index = {T,Ua,H}.
package rega_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   typedef struct packed {
      logic [3:0] dm;
      logic [3:0] um;
      logic [3:0] ds;
      logic [3:0] us;
   } bcdTime;

   // index 7 .. 0 : 30:00 15:00 15:00 07:30 22:00 15:30 15:00 07:30
   localparam logic [127:0] DEFAULT_PRESET_TABLE =
      128'h3000_1500_1500_0730_2200_1530_1500_0730;

   function automatic logic bcd_is_zero(input bcdTime t);
      return (t == '0);
   endfunction

endpackage

// File: rtl/rega_timer_bcd_counter.sv
// Four-digit MM:SS BCD down counter with borrow cascade.
// Priority: rst/clear > load > en; 00:00 is never decremented.
module bcd_down_counter
   import rega_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   clear,
   input  logic   load,
   input  bcdTime loadVal,
   input  logic   en,
   output bcdTime value,
   output logic   zero,
   output logic   atOne
);

   bcdTime decVal;

   always_comb begin
      decVal = value;
      if (value.us != 4'd0) begin
         decVal.us = value.us - 4'd1;
      end else begin
         decVal.us = 4'd9;
         if (value.ds != 4'd0) begin
            decVal.ds = value.ds - 4'd1;
         end else begin
            decVal.ds = 4'd5;
            if (value.um != 4'd0) begin
               decVal.um = value.um - 4'd1;
            end else begin
               decVal.um = 4'd9;
               decVal.dm = value.dm - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear)
         value <= '0;
      else if (load)
         value <= loadVal;
      else if (en && !zero)
         value <= decVal;
   end

   assign zero  = bcd_is_zero(value);
   // one second left: the next decrement lands on 00:00
   assign atOne = (value == bcdTime'(16'h0001));

endmodule

// File: rtl/rega_timer_bcd.sv
// Irrigation timer: loads an MM:SS preset chosen by {T,Ua,H}, counts it down
// once per TICK_DIV clocks with the valve open, supports pause and abort.
module rega_timer_bcd
   import rega_pkg::*;
#(
   parameter int unsigned  TICK_DIV     = 50000000,
   parameter logic [127:0] PRESET_TABLE = DEFAULT_PRESET_TABLE
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   input  logic       T,
   input  logic       Ua,
   input  logic       H,
   output logic       valve,
   output logic       busy,
   output logic       done,
   output logic [3:0] dm,
   output logic [3:0] um,
   output logic [3:0] ds,
   output logic [3:0] us
);

   localparam int            PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   stateT         state, stateNext;
   logic [PW-1:0] prescaler;
   logic [6:0]    tabBit;
   bcdTime        preset, digits;
   logic          cntLoad, cntEn, cntZero, cntAtOne, tick;

   assign tabBit = {T, Ua, H, 4'b0000};
   assign preset = bcdTime'(PRESET_TABLE[tabBit +: 16]);
   assign tick   = (state == RUN) && !pause && (prescaler == PRESC_MAX);

   always_comb begin
      stateNext = state;
      cntLoad   = 1'b0;
      cntEn     = 1'b0;
      if (abort) begin
         stateNext = IDLE;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               cntLoad   = 1'b1;
               stateNext = bcd_is_zero(preset) ? DONE : RUN;
            end
            RUN: if (tick && !cntZero) begin
               cntEn = 1'b1;
               if (cntAtOne) stateNext = DONE;
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // prescaler only advances while running un-paused; a fresh load restarts the second
   always_ff @(posedge clk) begin
      if (rst || abort || cntLoad)
         prescaler <= '0;
      else if (state == RUN && !pause)
         prescaler <= tick ? '0 : prescaler + 1'b1;
   end

   bcd_down_counter uCounter (
      .clk     (clk),
      .rst     (rst),
      .clear   (abort),
      .load    (cntLoad),
      .loadVal (preset),
      .en      (cntEn),
      .value   (digits),
      .zero    (cntZero),
      .atOne   (cntAtOne)
   );

   assign valve = (state == RUN);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);
   assign dm    = digits.dm;
   assign um    = digits.um;
   assign ds    = digits.ds;
   assign us    = digits.us;

endmodule

// File: tb/tb_rega_timer_bcd.sv
// Scoreboard bench: two timers (default and custom table) share stimulus; a
// seconds-based reference model predicts each cycle, a monitor compares.
module tb_rega_timer_bcd;

   localparam int           TD       = 4;
   localparam logic [127:0] DEF_TAB  = 128'h3000_1500_1500_0730_2200_1530_1500_0730;
   localparam logic [127:0] CUST_TAB = 128'h1234_0059_0010_0100_9959_0000_0001_1000;

   typedef struct packed {
      logic        valve;
      logic        busy;
      logic        done;
      logic [15:0] dig;
   } obsT;

   logic clk = 1'b0;
   logic rst, start, pause, abort, T, Ua, H;
   logic valve0, busy0, done0, valve1, busy1, done1;
   logic [3:0] dm0, um0, ds0, us0, dm1, um1, ds1, us1;
   logic [15:0] dig0, dig1;

   obsT q0[$];
   obsT q1[$];
   obsT e0, g0, e1, g1;
   int  compared = 0, mismatched = 0;
   int  vcnt0 = 0, dcnt0 = 0;
   int  mode[2], rem[2], phase[2];   // mode: 0 idle, 1 run, 2 done
   logic [15:0] defExp [8] = '{16'h0730, 16'h1500, 16'h1530, 16'h2200,
                               16'h0730, 16'h1500, 16'h1500, 16'h3000};

   always #5 clk = ~clk;

   rega_timer_bcd #(.TICK_DIV(TD), .PRESET_TABLE(DEF_TAB)) dut0 (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
      .T(T), .Ua(Ua), .H(H), .valve(valve0), .busy(busy0), .done(done0),
      .dm(dm0), .um(um0), .ds(ds0), .us(us0));

   rega_timer_bcd #(.TICK_DIV(TD), .PRESET_TABLE(CUST_TAB)) dut1 (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
      .T(T), .Ua(Ua), .H(H), .valve(valve1), .busy(busy1), .done(done1),
      .dm(dm1), .um(um1), .ds(ds1), .us(us1));

   assign dig0 = {dm0, um0, ds0, us0};
   assign dig1 = {dm1, um1, ds1, us1};

   function automatic int presetSec(input logic [127:0] tab, input int idx);
      logic [15:0] e;
      e = tab[idx*16 +: 16];
      return (int'(e[15:12]) * 10 + int'(e[11:8])) * 60 + int'(e[7:4]) * 10 + int'(e[3:0]);
   endfunction

   function automatic obsT expOut(input int m, input int r);
      obsT o;
      int  mins, secs;
      mins    = r / 60;
      secs    = r % 60;
      o.valve = (m == 1);
      o.busy  = (m == 1);
      o.done  = (m == 2);
      o.dig   = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
      return o;
   endfunction

   task automatic modelStep(input int d, input logic [127:0] tab, input logic r, s, p, a,
                            input int idx);
      if (r || a) begin
         mode[d] = 0; rem[d] = 0; phase[d] = 0;
      end else if (mode[d] == 0) begin
         if (s) begin
            rem[d]   = presetSec(tab, idx);
            phase[d] = 0;
            mode[d]  = (rem[d] == 0) ? 2 : 1;
         end
      end else if (mode[d] == 1) begin
         if (!p) begin
            if (phase[d] == TD - 1) begin
               phase[d] = 0;
               rem[d]   = rem[d] - 1;
               if (rem[d] == 0) mode[d] = 2;
            end else begin
               phase[d] = phase[d] + 1;
            end
         end
      end else begin
         mode[d] = 0;
      end
   endtask

   // drive one cycle at the falling edge, predict, return at the next falling edge
   task automatic step(input logic r, s, p, a, input int idx);
      rst = r; start = s; pause = p; abort = a;
      {T, Ua, H} = 3'(idx);
      modelStep(0, DEF_TAB, r, s, p, a, idx);
      modelStep(1, CUST_TAB, r, s, p, a, idx);
      q0.push_back(expOut(mode[0], rem[0]));
      q1.push_back(expOut(mode[1], rem[1]));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 7)));
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (q0.size() > 0) begin
         e0 = q0.pop_front();
         g0 = {valve0, busy0, done0, dig0};
         compared++;
         if (g0 !== e0) begin
            mismatched++;
            $display("FAIL sb dut0 t=%0t got=%0h want=%0h", $time, g0, e0);
         end
         if (valve0) vcnt0++;
         if (done0)  dcnt0++;
      end
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         g1 = {valve1, busy1, done1, dig1};
         compared++;
         if (g1 !== e1) begin
            mismatched++;
            $display("FAIL sb dut1 t=%0t got=%0h want=%0h", $time, g1, e1);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; {T, Ua, H} = 3'b000;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("reset dut0", {valve0, busy0, done0, dig0}, 0);
      chk("reset dut1", {valve1, busy1, done1, dig1}, 0);

      // full 07:30 run
      vcnt0 = 0; dcnt0 = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("load 07:30", {valve0, busy0, dig0}, {2'b11, 16'h0730});
      idle(1805);
      chk("valve cycles", vcnt0, 1800);
      chk("done pulses", dcnt0, 1);
      chk("idle after run", {valve0, dig0}, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);

      // table walk
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, i);
         chk($sformatf("table %0d", i), dig0, defExp[i]);
         idle(2);
         step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      end

      // borrow chain and one-second entry on the custom table
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("load 10:00", dig1, 16'h1000);
      idle(4);
      chk("borrow 09:59", dig1, 16'h0959);
      idle(4);
      chk("borrow 09:58", dig1, 16'h0958);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1);
      idle(4);
      chk("00:01 done", {done1, valve1}, 2'b10);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);

      // pause mid-run
      vcnt0 = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(100);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("paused valve", valve0, 1);
      idle(1710);
      chk("valve cycles paused", vcnt0, 1810);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);

      // abort on the tick cycle, then abort with start
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      chk("abort on tick", {valve0, done0, dig0}, 0);
      idle(1);
      chk("no done after abort", done0, 0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 3);
      chk("abort beats start", {valve0, dig0}, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 3);
      chk("start after abort", dig0, 16'h2200);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);

      // zero entry
      step(1'b0, 1'b1, 1'b0, 1'b0, 2);
      chk("zero entry done", {done1, valve1}, 2'b10);
      idle(1);
      chk("zero entry idle", {done1, valve1}, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);

      // reset mid-run
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(10);
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("rst mid-run", {valve0, busy0, done0, dig0}, 0);

      // start during RUN is ignored
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      idle(5);
      step(1'b0, 1'b1, 1'b0, 1'b0, 7);
      chk("start in run ignored", dig0, 16'h0729);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 59) == 0),
              int'($urandom_range(0, 7)));

      idle(2);
      chk("scoreboard drained", q0.size() + q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
